// File: rtl/chamfer_bp_engine.sv
// chamfer_bp_engine
// Backward (bottom-right to top-left) pass of the two-pass chamfer distance
// transform. Walks interior pixels in descending raster order, reads the
// centre and its E/SW/S/SE neighbours from a synchronous result RAM, and
// writes back the saturating weighted minimum only when it lowers the centre.
// Re-arms when fp_done drops after the pass has completed.
module chamfer_bp_engine #(
    parameter int IMG_W   = 128,
    parameter int IMG_H   = 128,
    parameter int DW      = 8,
    parameter int AW      = 14,
    parameter int ORTHO_W = 1,
    parameter int DIAG_W  = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          fp_done,
    output logic          res_rd,
    output logic          res_wr,
    output logic [AW-1:0] res_addr,
    output logic [DW-1:0] res_do,
    input  logic [DW-1:0] res_di,
    output logic          bp_done
);

    localparam int CW = $clog2(IMG_W);

    localparam logic [AW-1:0] LAST   = AW'((IMG_H - 2) * IMG_W + IMG_W - 2);
    localparam logic [AW-1:0] FIRST  = AW'(IMG_W + 1);
    localparam logic [AW-1:0] ROW    = AW'(IMG_W);
    localparam logic [AW-1:0] ONE    = AW'(1);
    localparam logic [AW-1:0] THREE  = AW'(3);
    localparam logic [CW-1:0] COL1   = CW'(1);
    localparam logic [DW-1:0] MAXV   = '1;
    localparam logic [DW:0]   W_ORTH = (DW + 1)'(ORTHO_W);
    localparam logic [DW:0]   W_DIAG = (DW + 1)'(DIAG_W);

    typedef enum logic [3:0] {
        IDLE,
        ISSUE_C,
        CAP_C,
        ISSUE_E,
        ISSUE_SW,
        ISSUE_S,
        ISSUE_SE,
        CAP_SE,
        WB,
        NEXT,
        DONE
    } state_t;

    state_t        state;
    logic [AW-1:0] cur;
    logic [AW-1:0] cur_step;
    logic [DW-1:0] target;
    logic [DW-1:0] nb_e;
    logic [DW-1:0] nb_sw;
    logic [DW-1:0] nb_s;
    logic [DW-1:0] nv;

    // Neighbour plus weight, computed one bit wider so overflow clamps to
    // the maximum distance instead of wrapping around to a small value.
    function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a,
                                              input logic [DW:0]   w);
        logic [DW:0] s;
        s = {1'b0, a} + w;
        if (s > {1'b0, MAXV})
            return MAXV;
        return s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] min2(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Candidate value for the centre; evaluated in CAP_SE where the SE
    // neighbour is still on the read data bus.
    always_comb begin
        nv = target;
        nv = min2(nv, sat_add(nb_e,   W_ORTH));
        nv = min2(nv, sat_add(nb_s,   W_ORTH));
        nv = min2(nv, sat_add(nb_sw,  W_DIAG));
        nv = min2(nv, sat_add(res_di, W_DIAG));
    end

    // Next interior centre: skip the right border of the row above and the
    // left border of this row when leaving column 1.
    always_comb begin
        cur_step = (cur[CW-1:0] == COL1) ? (cur - THREE) : (cur - ONE);
    end

    // Capture centre and neighbour samples as each read returns.
    always_ff @(posedge clk) begin
        case (state)
            CAP_C:    target <= res_di;
            ISSUE_SW: nb_e   <= res_di;
            ISSUE_S:  nb_sw  <= res_di;
            ISSUE_SE: nb_s   <= res_di;
            default:  ;
        endcase
    end

    // Scan FSM; strobes and address are registered on entry to each state
    // so they are valid for the whole cycle the FSM sits in that state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cur      <= LAST;
            res_rd   <= 1'b0;
            res_wr   <= 1'b0;
            res_addr <= '0;
            res_do   <= '0;
            bp_done  <= 1'b0;
        end else begin
            res_rd <= 1'b0;
            res_wr <= 1'b0;
            case (state)
                IDLE: begin
                    bp_done <= 1'b0;
                    if (fp_done) begin
                        state    <= ISSUE_C;
                        cur      <= LAST;
                        res_rd   <= 1'b1;
                        res_addr <= LAST;
                    end
                end
                ISSUE_C: begin
                    state <= CAP_C;
                end
                CAP_C: begin
                    if (res_di == '0) begin
                        // Zero is already the minimum; skip the neighbourhood.
                        state <= NEXT;
                    end else begin
                        state    <= ISSUE_E;
                        res_rd   <= 1'b1;
                        res_addr <= cur + ONE;
                    end
                end
                ISSUE_E: begin
                    state    <= ISSUE_SW;
                    res_rd   <= 1'b1;
                    res_addr <= cur + ROW - ONE;
                end
                ISSUE_SW: begin
                    state    <= ISSUE_S;
                    res_rd   <= 1'b1;
                    res_addr <= cur + ROW;
                end
                ISSUE_S: begin
                    state    <= ISSUE_SE;
                    res_rd   <= 1'b1;
                    res_addr <= cur + ROW + ONE;
                end
                ISSUE_SE: begin
                    state <= CAP_SE;
                end
                CAP_SE: begin
                    state <= WB;
                    // Only write when the distance actually drops.
                    if (nv < target) begin
                        res_wr   <= 1'b1;
                        res_addr <= cur;
                        res_do   <= nv;
                    end
                end
                WB: begin
                    state <= NEXT;
                end
                NEXT: begin
                    if (cur == FIRST) begin
                        state   <= DONE;
                        bp_done <= 1'b1;
                    end else begin
                        state    <= ISSUE_C;
                        cur      <= cur_step;
                        res_rd   <= 1'b1;
                        res_addr <= cur_step;
                    end
                end
                DONE: begin
                    if (!fp_done) begin
                        state   <= IDLE;
                        bp_done <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chamfer_bp_engine.sv
// Testbench for chamfer_bp_engine on a 4x4 image with ORTHO_W=1, DIAG_W=2.
// A behavioural RAM serves the engine; a reference backward pass fills read
// and write scoreboards that a negedge monitor drains as the DUT acts.
module tb_chamfer_bp_engine;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int OW = 1;
    localparam int DG = 2;
    localparam int N  = W * H;
    localparam int LASTP = (H - 2) * W + W - 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          fp_done = 1'b0;
    logic          res_rd;
    logic          res_wr;
    logic [AW-1:0] res_addr;
    logic [DW-1:0] res_do;
    logic [DW-1:0] res_di;
    logic          bp_done;

    logic [DW-1:0] mem [N];
    logic [DW-1:0] init_img [N];
    logic          load = 1'b0;
    logic [DW-1:0] rdata = '0;

    int rd_q[$];
    int wa_q[$];
    int wd_q[$];
    int exp_img [N];
    int last_wd;
    int n_chk = 0;
    int n_fail = 0;

    chamfer_bp_engine #(
        .IMG_W(W), .IMG_H(H), .DW(DW), .AW(AW), .ORTHO_W(OW), .DIAG_W(DG)
    ) dut (
        .clk(clk), .rstn(rstn), .fp_done(fp_done),
        .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr),
        .res_do(res_do), .res_di(res_di), .bp_done(bp_done)
    );

    always #5 clk = ~clk;

    assign res_di = rdata;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < N; i++) mem[i] <= init_img[i];
        end else begin
            if (res_rd) rdata <= mem[res_addr];
            if (res_wr) mem[res_addr] <= res_do;
        end
    end

    // Scoreboard monitor: every read and write must match the next expected one.
    always @(negedge clk) begin
        if (rstn) begin
            if (res_rd && res_wr) begin
                n_chk++; n_fail++;
                $display("FAIL rd_wr_excl: rd=%0b wr=%0b both high, required not both", res_rd, res_wr);
            end
            if (res_rd) begin
                n_chk++;
                if (rd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_unexpected: read addr %0d, required no read", res_addr);
                end else begin
                    int e;
                    e = rd_q.pop_front();
                    if (int'(res_addr) !== e) begin
                        n_fail++;
                        $display("FAIL rd_addr: got %0d, required %0d", res_addr, e);
                    end
                end
            end
            if (res_wr) begin
                n_chk++;
                if (wa_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_unexpected: write addr %0d data %0d, required no write", res_addr, res_do);
                end else begin
                    int ea, ed;
                    ea = wa_q.pop_front();
                    ed = wd_q.pop_front();
                    if (int'(res_addr) !== ea || int'(res_do) !== ed) begin
                        n_fail++;
                        $display("FAIL wr: got addr %0d data %0d, required addr %0d data %0d",
                                 res_addr, res_do, ea, ed);
                    end
                end
            end
        end
    end

    function automatic int satv(input int a, input int w);
        return (a + w > 255) ? 255 : a + w;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic load_image();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Reference backward pass over the current RAM contents.
    task automatic build_expect(output int cyc);
        int img [N];
        for (int i = 0; i < N; i++) img[i] = int'(mem[i]);
        cyc = 0;
        for (int r = H - 2; r >= 1; r--) begin
            for (int c = W - 2; c >= 1; c--) begin
                int p, nv;
                p = r * W + c;
                rd_q.push_back(p);
                if (img[p] == 0) begin
                    cyc += 3;
                end else begin
                    cyc += 9;
                    rd_q.push_back(p + 1);
                    rd_q.push_back(p + W - 1);
                    rd_q.push_back(p + W);
                    rd_q.push_back(p + W + 1);
                    nv = img[p];
                    nv = imin(nv, satv(img[p + 1], OW));
                    nv = imin(nv, satv(img[p + W], OW));
                    nv = imin(nv, satv(img[p + W - 1], DG));
                    nv = imin(nv, satv(img[p + W + 1], DG));
                    if (nv < img[p]) begin
                        wa_q.push_back(p);
                        wd_q.push_back(nv);
                        img[p] = nv;
                        last_wd = nv;
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) exp_img[i] = img[i];
    endtask

    // Wait for the first read, then count cycles until bp_done rises.
    task automatic wait_pass(output int cyc, output bit to);
        int t;
        t = 0;
        to = 1'b0;
        do begin
            @(negedge clk);
            t++;
        end while (!res_rd && t < 200);
        if (!res_rd) to = 1'b1;
        cyc = 0;
        while (!bp_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (!bp_done) to = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        fp_done = 1'b0;
        last_wd = 0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({res_rd, res_wr, res_addr, res_do, bp_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rd=%0b wr=%0b addr=%0d do=%0d done=%0b, required all 0",
                     res_rd, res_wr, res_addr, res_do, bp_done);
        end
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (res_rd !== 1'b0 || bp_done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_quiet: rd=%0b done=%0b with fp_done low, required 0 0", res_rd, bp_done);
        end
    endtask

    // Runs one pass from the loaded image and checks cycles, queues and RAM.
    task automatic pass_and_check(input string name);
        int ec, gc;
        bit to;
        build_expect(ec);
        fp_done = 1'b1;
        wait_pass(gc, to);
        n_chk++;
        if (to || gc != ec) begin
            n_fail++;
            $display("FAIL %s_cycles: got %0d (timeout=%0b), required %0d", name, gc, to, ec);
        end
        n_chk++;
        if (rd_q.size() != 0 || wa_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: %0d reads %0d writes left, required 0 0",
                     name, rd_q.size(), wa_q.size());
        end
        for (int i = 0; i < N; i++) begin
            n_chk++;
            if (int'(mem[i]) !== exp_img[i]) begin
                n_fail++;
                $display("FAIL %s_ram[%0d]: got %0d, required %0d", name, i, mem[i], exp_img[i]);
            end
        end
        rd_q.delete(); wa_q.delete(); wd_q.delete();
    endtask

    task automatic end_pass();
        fp_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_zero_centres();
        for (int i = 0; i < N; i++) init_img[i] = '0;
        load_image();
        pass_and_check("zero");
        end_pass();
    endtask

    task automatic test_weights();
        for (int i = 0; i < N; i++) init_img[i] = '0;
        init_img[10] = 8'd200;
        init_img[11] = 8'd3;
        init_img[13] = 8'd7;
        init_img[14] = 8'd9;
        init_img[15] = 8'd1;
        load_image();
        pass_and_check("weights");
        n_chk++;
        if (mem[10] !== 8'd3) begin
            n_fail++;
            $display("FAIL weights_centre: got %0d, required 3", mem[10]);
        end
        end_pass();
        n_chk++;
        if (res_do !== 8'(last_wd) || res_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL do_hold: do=%0d wr=%0b, required do=%0d wr=0", res_do, res_wr, last_wd);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < N; i++) init_img[i] = 8'd255;
        load_image();
        pass_and_check("sat");
        end_pass();
        n_chk++;
        if (res_do !== 8'(last_wd)) begin
            n_fail++;
            $display("FAIL sat_do_hold: do=%0d, required %0d", res_do, last_wd);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++)
                init_img[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            load_image();
            pass_and_check("random");
            end_pass();
        end
    endtask

    task automatic test_reset_mid_run();
        int t, ec, gc;
        bit to;
        for (int i = 0; i < N; i++) init_img[i] = 8'($urandom_range(20, 250));
        load_image();
        build_expect(ec);
        fp_done = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(res_rd && res_addr == AW'(LASTP + W)) && t < 200);
        n_chk++;
        if (t >= 200) begin
            n_fail++;
            $display("FAIL midrst_reach: S read of %0d not seen, required within 200 cycles", LASTP);
        end
        rstn = 1'b0;
        #1;
        n_chk++;
        if ({res_rd, res_wr, res_addr, res_do, bp_done} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: rd=%0b wr=%0b addr=%0d do=%0d done=%0b, required all 0",
                     res_rd, res_wr, res_addr, res_do, bp_done);
        end
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        last_wd = 0;
        @(negedge clk);
        build_expect(ec);
        rstn = 1'b1;
        wait_pass(gc, to);
        n_chk++;
        if (to || gc != ec) begin
            n_fail++;
            $display("FAIL midrst_cycles: got %0d (timeout=%0b), required %0d", gc, to, ec);
        end
        n_chk++;
        if (rd_q.size() != 0 || wa_q.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_pending: %0d reads %0d writes left, required 0 0",
                     rd_q.size(), wa_q.size());
        end
        rd_q.delete(); wa_q.delete(); wd_q.delete();
    endtask

    // Continues from the completed pass above with fp_done still high.
    task automatic test_rearm();
        repeat (5) begin
            @(negedge clk);
            n_chk++;
            if (bp_done !== 1'b1 || res_rd !== 1'b0) begin
                n_fail++;
                $display("FAIL done_hold: done=%0b rd=%0b, required 1 0", bp_done, res_rd);
            end
        end
        fp_done = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bp_done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_clear: got %0b, required 0", bp_done);
        end
        pass_and_check("rearm");
        end_pass();
    endtask

    initial begin
        test_reset();
        test_zero_centres();
        test_weights();
        test_saturation();
        test_random();
        test_reset_mid_run();
        test_rearm();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
